// File: rtl/pong_ball_ctrl.sv
// Ball motion, paddle/wall bounce, scoring and serve/play/over sequencing for the pong server.
// Optional BALL_SPEEDUP_EN: each paddle hit raises the ball step up to MAX_STEP, and each serve restores it.
module pong_ball_ctrl #(
  parameter int SCREEN_W    = 800,
  parameter int SCREEN_H    = 600,
  parameter int BALL_SIZE   = 10,
  parameter int PADDLE_H    = 100,
  parameter int PADDLE_W    = 10,
  parameter int PADDLE_X1   = 40,
  parameter int PADDLE_X2   = 750,
  parameter int BALL_STEP   = 4,
  parameter int MAX_STEP    = 12,
  parameter int TICK_DIV    = 833333,
  parameter int SERVE_TICKS = 60,
  parameter int WIN_SCORE   = 7
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [10:0] p1_y,
  input  logic [10:0] p2_y,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic [3:0]  score1,
  output logic [3:0]  score2,
  output logic        frame_tick,
  output logic        game_over
);

  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SERVE_W = $clog2(SERVE_TICKS + 1);
  localparam int STEP_W  = $clog2(MAX_STEP + 1);

  localparam logic [10:0]         CX         = 11'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [10:0]         CY         = 11'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic signed [11:0]  X_MAX      = 12'(SCREEN_W - BALL_SIZE);
  localparam logic signed [11:0]  Y_MAX      = 12'(SCREEN_H - BALL_SIZE);
  localparam logic signed [11:0]  P1_FACE    = 12'(PADDLE_X1 + PADDLE_W);
  localparam logic signed [11:0]  P2_FACE    = 12'(PADDLE_X2 - BALL_SIZE);
  localparam logic [STEP_W-1:0]   STEP_INIT  = STEP_W'(BALL_STEP);
  localparam logic [TICK_W-1:0]   TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [SERVE_W-1:0]  SERVE_LAST = SERVE_W'(SERVE_TICKS - 1);
  localparam logic [3:0]          WIN        = 4'(WIN_SCORE);

  typedef enum logic [1:0] {S_IDLE, S_SERVE, S_PLAY, S_OVER} state_t;

  state_t               state_q, state_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [SERVE_W-1:0]   serve_cnt_q, serve_cnt_d;
  logic [10:0]          ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic                 dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
  logic [3:0]           score1_q, score1_d, score2_q, score2_d;
  logic                 game_over_q, game_over_d;
  logic [STEP_W-1:0]    step;
  logic signed [11:0]   bx_s, by_s, step_s, nx, ny;
  logic [12:0]          by_bot, p1_bot, p2_bot;
  logic                 p1_hit, p2_hit, miss_l, miss_r;
  logic [3:0]           score1_inc, score2_inc;

  assign frame_tick = (tick_cnt_q == TICK_LAST);
  assign ball_x     = ball_x_q;
  assign ball_y     = ball_y_q;
  assign score1     = score1_q;
  assign score2     = score2_q;
  assign game_over  = game_over_q;

  // Candidate next position and collision predicates, all against the pre-move ball.
  always_comb begin
    bx_s   = signed'({1'b0, ball_x_q});
    by_s   = signed'({1'b0, ball_y_q});
    step_s = signed'(12'(step));
    nx     = dx_neg_q ? (bx_s - step_s) : (bx_s + step_s);
    ny     = dy_neg_q ? (by_s - step_s) : (by_s + step_s);
    by_bot = 13'(ball_y_q) + 13'(BALL_SIZE);
    p1_bot = 13'(p1_y) + 13'(PADDLE_H);
    p2_bot = 13'(p2_y) + 13'(PADDLE_H);
    p1_hit = dx_neg_q && (nx <= P1_FACE) && (bx_s >= P1_FACE) &&
             (by_bot > 13'(p1_y)) && (13'(ball_y_q) < p1_bot);
    p2_hit = !dx_neg_q && (nx >= P2_FACE) && (bx_s <= P2_FACE) &&
             (by_bot > 13'(p2_y)) && (13'(ball_y_q) < p2_bot);
    miss_l = (nx <= 12'sd0);
    miss_r = (nx >= X_MAX);
    score1_inc = score1_q + 4'd1;
    score2_inc = score2_q + 4'd1;
  end

  always_comb begin
    tick_cnt_d  = frame_tick ? '0 : tick_cnt_q + 1'b1;
    state_d     = state_q;
    serve_cnt_d = serve_cnt_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dx_neg_d    = dx_neg_q;
    dy_neg_d    = dy_neg_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    game_over_d = game_over_q;
    if (start) begin
      state_d     = S_SERVE;
      serve_cnt_d = '0;
      score1_d    = '0;
      score2_d    = '0;
      ball_x_d    = CX;
      ball_y_d    = CY;
      game_over_d = 1'b0;
    end else if (frame_tick) begin
      case (state_q)
        S_SERVE: begin
          serve_cnt_d = serve_cnt_q + 1'b1;
          if (serve_cnt_q == SERVE_LAST) state_d = S_PLAY;
        end
        S_PLAY: begin
          if (ny <= 12'sd0) begin
            ball_y_d = '0;
            dy_neg_d = 1'b0;
          end else if (ny >= Y_MAX) begin
            ball_y_d = Y_MAX[10:0];
            dy_neg_d = 1'b1;
          end else begin
            ball_y_d = ny[10:0];
          end
          // Paddle contact wins over a miss on the same tick.
          if (p1_hit) begin
            ball_x_d = P1_FACE[10:0];
            dx_neg_d = 1'b0;
          end else if (p2_hit) begin
            ball_x_d = P2_FACE[10:0];
            dx_neg_d = 1'b1;
          end else if (miss_l || miss_r) begin
            ball_x_d    = CX;
            ball_y_d    = CY;
            dx_neg_d    = miss_l;
            dy_neg_d    = dy_neg_q;
            serve_cnt_d = '0;
            if (miss_l) score2_d = score2_inc;
            else        score1_d = score1_inc;
            if ((miss_l && score2_inc == WIN) || (miss_r && score1_inc == WIN)) begin
              state_d     = S_OVER;
              game_over_d = 1'b1;
            end else begin
              state_d = S_SERVE;
            end
          end else begin
            ball_x_d = nx[10:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      serve_cnt_q <= '0;
      ball_x_q    <= CX;
      ball_y_q    <= CY;
      dx_neg_q    <= 1'b0;
      dy_neg_q    <= 1'b0;
      score1_q    <= '0;
      score2_q    <= '0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      serve_cnt_q <= serve_cnt_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      dx_neg_q    <= dx_neg_d;
      dy_neg_q    <= dy_neg_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      game_over_q <= game_over_d;
    end
  end

`ifdef BALL_SPEEDUP_EN
  logic [STEP_W-1:0] step_q, step_d;
  logic              play_tick;

  function automatic logic [STEP_W-1:0] sat_step_inc(input logic [STEP_W-1:0] s);
    if (s >= STEP_W'(MAX_STEP)) return STEP_W'(MAX_STEP);
    return s + 1'b1;
  endfunction

  always_comb begin
    play_tick = (state_q == S_PLAY) && frame_tick && !start;
    step_d    = step_q;
    if (start || (play_tick && !p1_hit && !p2_hit && (miss_l || miss_r)))
      step_d = STEP_INIT;
    else if (play_tick && (p1_hit || p2_hit))
      step_d = sat_step_inc(step_q);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) step_q <= STEP_INIT;
    else          step_q <= step_d;
  end

  assign step = step_q;
`else
  assign step = STEP_INIT;
`endif

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Directed bench for pong_ball_ctrl with a short frame tick (4 clocks) and a 2-tick serve.
module tb_pong_ball_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [10:0] p1_y = 11'd100;
  logic [10:0] p2_y = 11'd500;
  logic [10:0] ball_x, ball_y;
  logic [3:0]  score1, score2;
  logic        frame_tick, game_over;

  int checks = 0;
  int errors = 0;

  pong_ball_ctrl #(.TICK_DIV(4), .SERVE_TICKS(2)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .p1_y(p1_y), .p2_y(p2_y),
    .ball_x(ball_x), .ball_y(ball_y),
    .score1(score1), .score2(score2),
    .frame_tick(frame_tick), .game_over(game_over)
  );

  always #5 clock = ~clock;

  // Advance to just after the next clock edge on which frame_tick is high.
  task automatic tick();
    int n;
    n = 0;
    @(negedge clock);
    while (frame_tick !== 1'b1 && n < 8) begin
      @(negedge clock);
      n++;
    end
    if (frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL tick_timeout frame_tick=%b required 1", frame_tick);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_score(input bit second, input logic [3:0] val);
    int n;
    n = 0;
    while (((second ? score2 : score1) !== val) && n < 4000) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if ((second ? score2 : score1) !== val) begin
      errors++;
      $display("FAIL score_wait s1=%0d s2=%0d required %s=%0d", score1, score2,
               second ? "s2" : "s1", val);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++;
    if (ball_x !== 11'd395 || ball_y !== 11'd295 || score1 !== 4'd0 || score2 !== 4'd0 ||
        game_over !== 1'b0) begin
      errors++;
      $display("FAIL reset_state ball=(%0d,%0d) s=%0d/%0d go=%b required (395,295) 0/0 0",
               ball_x, ball_y, score1, score2, game_over);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (frame_tick !== ((i % 4) == 3)) begin
        errors++;
        $display("FAIL frame_tick clk=%0d got %b required %b", i, frame_tick, (i % 4) == 3);
      end
      @(negedge clock);
    end
    checks++;
    if (ball_x !== 11'd395 || ball_y !== 11'd295 || score1 !== 4'd0 || score2 !== 4'd0) begin
      errors++;
      $display("FAIL idle_hold ball=(%0d,%0d) s=%0d/%0d required (395,295) 0/0",
               ball_x, ball_y, score1, score2);
    end
  endtask

  task automatic test_serve();
    pulse_start();
    tick();
    checks++;
    if (ball_x !== 11'd395 || ball_y !== 11'd295) begin
      errors++;
      $display("FAIL serve_hold1 ball=(%0d,%0d) required (395,295)", ball_x, ball_y);
    end
    tick();
    checks++;
    if (ball_x !== 11'd395 || ball_y !== 11'd295) begin
      errors++;
      $display("FAIL serve_hold2 ball=(%0d,%0d) required (395,295)", ball_x, ball_y);
    end
    tick();
    checks++;
    if (ball_x !== 11'd399 || ball_y !== 11'd299) begin
      errors++;
      $display("FAIL first_move ball=(%0d,%0d) required (399,299)", ball_x, ball_y);
    end
  endtask

  task automatic test_walls();
    ticks(73);
    checks++;
    if (ball_x !== 11'd691 || ball_y !== 11'd590) begin
      errors++;
      $display("FAIL bottom_clamp ball=(%0d,%0d) required (691,590)", ball_x, ball_y);
    end
    tick();
    checks++;
    if (ball_x !== 11'd695 || ball_y !== 11'd586) begin
      errors++;
      $display("FAIL bottom_bounce ball=(%0d,%0d) required (695,586)", ball_x, ball_y);
    end
    ticks(12);
    checks++;
    if (ball_x !== 11'd740 || ball_y !== 11'd538) begin
      errors++;
      $display("FAIL p2_hit ball=(%0d,%0d) required (740,538)", ball_x, ball_y);
    end
    tick();
    checks++;
    if (ball_x !== 11'd736 || ball_y !== 11'd534) begin
      errors++;
      $display("FAIL p2_rebound ball=(%0d,%0d) required (736,534)", ball_x, ball_y);
    end
    ticks(133);
    checks++;
    if (ball_x !== 11'd204 || ball_y !== 11'd2) begin
      errors++;
      $display("FAIL near_top ball=(%0d,%0d) required (204,2)", ball_x, ball_y);
    end
    tick();
    checks++;
    if (ball_x !== 11'd200 || ball_y !== 11'd0) begin
      errors++;
      $display("FAIL top_clamp ball=(%0d,%0d) required (200,0)", ball_x, ball_y);
    end
    tick();
    checks++;
    if (ball_x !== 11'd196 || ball_y !== 11'd4) begin
      errors++;
      $display("FAIL top_bounce ball=(%0d,%0d) required (196,4)", ball_x, ball_y);
    end
  endtask

  task automatic test_p1_hit();
    ticks(36);
    checks++;
    if (ball_x !== 11'd52 || ball_y !== 11'd148) begin
      errors++;
      $display("FAIL p1_approach ball=(%0d,%0d) required (52,148)", ball_x, ball_y);
    end
    tick();
    checks++;
    if (ball_x !== 11'd50 || ball_y !== 11'd152) begin
      errors++;
      $display("FAIL p1_hit ball=(%0d,%0d) required (50,152)", ball_x, ball_y);
    end
    tick();
    checks++;
    if (ball_x !== 11'd54 || ball_y !== 11'd156) begin
      errors++;
      $display("FAIL p1_rebound ball=(%0d,%0d) required (54,156)", ball_x, ball_y);
    end
    p2_y = 11'd300;
    p1_y = 11'd1000;
    ticks(172);
    checks++;
    if (ball_x !== 11'd740 || ball_y !== 11'd338) begin
      errors++;
      $display("FAIL p2_hit2 ball=(%0d,%0d) required (740,338)", ball_x, ball_y);
    end
  endtask

  task automatic test_p1_miss();
    wait_score(1'b1, 4'd1);
    checks++;
    if (score1 !== 4'd0 || ball_x !== 11'd395 || ball_y !== 11'd295 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL p1_miss s1=%0d ball=(%0d,%0d) go=%b required 0 (395,295) 0",
               score1, ball_x, ball_y, game_over);
    end
    p1_y = 11'd500;
    ticks(3);
    checks++;
    if (ball_x !== 11'd391 || ball_y !== 11'd299) begin
      errors++;
      $display("FAIL serve_toward_p1 ball=(%0d,%0d) required (391,299)", ball_x, ball_y);
    end
  endtask

  task automatic test_restart();
    pulse_start();
    checks++;
    if (score2 !== 4'd0 || ball_x !== 11'd395 || ball_y !== 11'd295) begin
      errors++;
      $display("FAIL restart s2=%0d ball=(%0d,%0d) required 0 (395,295)", score2, ball_x, ball_y);
    end
    ticks(3);
    checks++;
    if (ball_x !== 11'd391 || ball_y !== 11'd299) begin
      errors++;
      $display("FAIL restart_serve ball=(%0d,%0d) required (391,299)", ball_x, ball_y);
    end
    ticks(85);
    checks++;
    if (ball_x !== 11'd51 || ball_y !== 11'd542) begin
      errors++;
      $display("FAIL p1_approach2 ball=(%0d,%0d) required (51,542)", ball_x, ball_y);
    end
    tick();
    checks++;
    if (ball_x !== 11'd50 || ball_y !== 11'd538) begin
      errors++;
      $display("FAIL p1_hit2 ball=(%0d,%0d) required (50,538)", ball_x, ball_y);
    end
  endtask

  task automatic test_game_over();
    p2_y = 11'd1000;
    for (int i = 1; i <= 7; i++) begin
      wait_score(1'b0, 4'(i));
      checks++;
      if (ball_x !== 11'd395 || ball_y !== 11'd295 || game_over !== (i == 7)) begin
        errors++;
        $display("FAIL p2_miss_%0d ball=(%0d,%0d) go=%b required (395,295) %b",
                 i, ball_x, ball_y, game_over, i == 7);
      end
    end
    checks++;
    if (score2 !== 4'd0) begin
      errors++;
      $display("FAIL score2_kept got %0d required 0", score2);
    end
    ticks(3);
    checks++;
    if (ball_x !== 11'd395 || ball_y !== 11'd295 || score1 !== 4'd7 || game_over !== 1'b1) begin
      errors++;
      $display("FAIL over_frozen ball=(%0d,%0d) s1=%0d go=%b required (395,295) 7 1",
               ball_x, ball_y, score1, game_over);
    end
    pulse_start();
    checks++;
    if (score1 !== 4'd0 || score2 !== 4'd0 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL over_restart s=%0d/%0d go=%b required 0/0 0", score1, score2, game_over);
    end
    ticks(2);
    checks++;
    if (ball_x !== 11'd395) begin
      errors++;
      $display("FAIL over_serve_hold x=%0d required 395", ball_x);
    end
    tick();
    checks++;
    if (ball_x !== 11'd399) begin
      errors++;
      $display("FAIL over_serve_move x=%0d required 399", ball_x);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (ball_x !== 11'd395 || ball_y !== 11'd295 || score1 !== 4'd0 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL async_reset ball=(%0d,%0d) s1=%0d go=%b required (395,295) 0 0",
               ball_x, ball_y, score1, game_over);
    end
    @(negedge clock);
    reset_n = 1'b1;
    ticks(3);
    checks++;
    if (ball_x !== 11'd395 || ball_y !== 11'd295) begin
      errors++;
      $display("FAIL idle_after_reset ball=(%0d,%0d) required (395,295)", ball_x, ball_y);
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_walls();
    test_p1_hit();
    test_p1_miss();
    test_restart();
    test_game_over();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
